// File: rtl/speed_ctrl_pkg.sv
// Shared constants for the speed controller: default prescale periods,
// speed_sel encoding and count direction encoding.
package speed_ctrl_pkg;

    // Default periods in clk cycles for a 146.6 MHz clock
    localparam int P_250MS = 36_650_000;
    localparam int P_125MS = 18_325_000;
    localparam int P_62MS  = 9_162_500;
    localparam int P_31MS  = 4_581_250;

    localparam logic [1:0] SPD_X1 = 2'd0;
    localparam logic [1:0] SPD_X2 = 2'd1;
    localparam logic [1:0] SPD_X4 = 2'd2;
    localparam logic [1:0] SPD_X8 = 2'd3;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/speed_prescaler.sv
// Free-running clock divider: counts 0..period-1 while enabled and flags the
// terminal cycle. A restart zeroes the count and suppresses the terminal flag.
module speed_prescaler #(
    parameter int PRE_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [PRE_W-1:0] period,
    output logic             term
);

    logic [PRE_W-1:0] pre;
    logic             at_end;

    assign at_end = (pre == period - PRE_W'(1));
    assign term   = en && !restart && at_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (restart) begin
            pre <= '0;
        end else if (en) begin
            pre <= at_end ? '0 : pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/speed_ctrl_gen.sv
// Selectable-rate tick generator driving a modulo-N up/down counter with
// clear, load and wrap output. Define SPEED_CTRL_SAT_EN to saturate instead of wrap.
module speed_ctrl_gen
    import speed_ctrl_pkg::*;
#(
    parameter int PRE_W   = 26,
    parameter int P0      = P_250MS,
    parameter int P1      = P_125MS,
    parameter int P2      = P_62MS,
    parameter int P3      = P_31MS,
    parameter int CNT_W   = 6,
    parameter int CNT_MOD = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       speed_sel,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MOD - 1);

    logic [1:0]       sel_q;
    logic [PRE_W-1:0] period;
    logic             sel_chg;
    logic             restart;
    logic             term;
    logic             at_lim;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] load_clamped;

    always_comb begin
        case (sel_q)
            SPD_X1:  period = PRE_W'(P0);
            SPD_X2:  period = PRE_W'(P1);
            SPD_X4:  period = PRE_W'(P2);
            default: period = PRE_W'(P3);
        endcase
    end

    // A speed change restarts the period so the new rate starts cleanly
    assign sel_chg = (speed_sel != sel_q);
    assign restart = clr || sel_chg;

    speed_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .restart (restart),
        .period  (period),
        .term    (term)
    );

    always_comb begin
        at_lim = (dir == DIR_DN) ? (cnt == '0) : (cnt == CNT_MAX);
`ifdef SPEED_CTRL_SAT_EN
        if (at_lim)
            cnt_nxt = cnt;
`else
        if (at_lim)
            cnt_nxt = (dir == DIR_DN) ? CNT_MAX : '0;
`endif
        else if (dir == DIR_DN)
            cnt_nxt = cnt - CNT_W'(1);
        else
            cnt_nxt = cnt + CNT_W'(1);
    end

    assign load_clamped = (load_val > CNT_MAX) ? CNT_MAX : load_val;

    // A load on the terminal cycle consumes that step without counting it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= SPD_X1;
            cnt   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else begin
                if (sel_chg)
                    sel_q <= speed_sel;
                if (load) begin
                    cnt <= load_clamped;
                end else if (term) begin
                    cnt  <= cnt_nxt;
                    tick <= 1'b1;
                    wrap <= at_lim;
                end
            end
        end
    end

endmodule

// File: tb/tb_speed_ctrl_gen.sv
// Self-checking bench for speed_ctrl_gen with small periods (4/3/2/5) and a
// modulo-6 counter; works with or without SPEED_CTRL_SAT_EN defined.
module tb_speed_ctrl_gen;

    localparam int MOD = 6;
`ifdef SPEED_CTRL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, dir, clr, load;
    logic [1:0] speed_sel;
    logic [2:0] load_val;
    logic [2:0] cnt;
    logic       tick, wrap;

    always #5 clk = ~clk;

    speed_ctrl_gen #(
        .PRE_W(4), .P0(4), .P1(3), .P2(2), .P3(5), .CNT_W(3), .CNT_MOD(MOD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .speed_sel(speed_sel), .dir(dir),
        .clr(clr), .load(load), .load_val(load_val),
        .cnt(cnt), .tick(tick), .wrap(wrap)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: elapsed cycles in the current period, active speed, count
    int m_pre, m_sel, m_cnt;
    bit m_tick, m_wrap, prev_tick;

    typedef struct {
        bit r; bit e; int sel; bit d; bit c; bit l; int lv;
        int ec; bit et; bit ew;
    } vec_t;
    vec_t vq[$];

    function automatic int per(int s);
        case (s)
            0: return 4;
            1: return 3;
            2: return 2;
            default: return 5;
        endcase
    endfunction

    task automatic model_edge();
        bit term;
        m_tick = 0;
        m_wrap = 0;
        if (!rst_n) begin
            m_pre = 0; m_sel = 0; m_cnt = 0;
        end else if (clr) begin
            m_pre = 0; m_cnt = 0;
        end else if (int'(speed_sel) != m_sel) begin
            m_sel = int'(speed_sel);
            m_pre = 0;
            if (load) m_cnt = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
        end else begin
            term = en && (m_pre == per(m_sel) - 1);
            if (term) m_pre = 0;
            else if (en) m_pre = m_pre + 1;
            if (load) begin
                m_cnt = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
            end else if (term) begin
                m_tick = 1;
                if (!dir) begin
                    m_wrap = (m_cnt == MOD - 1);
                    m_cnt = m_wrap ? (SAT ? m_cnt : 0) : m_cnt + 1;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt = m_wrap ? (SAT ? m_cnt : MOD - 1) : m_cnt - 1;
                end
            end
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model_cnt", int'(cnt), m_cnt);
        check("model_tick", int'(tick), int'(m_tick));
        check("model_wrap", int'(wrap), int'(m_wrap));
        check("no_double_tick", int'(prev_tick && tick), 0);
        prev_tick = tick;
    endtask

    task automatic wait_tick(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n++;
            if (tick) return;
        end
        check({nm, "_timeout"}, 1, 0);
    endtask

    task automatic addv(input bit r, input bit e, input int s, input bit d, input bit c,
                        input bit l, input int lv, input int ec, input bit et, input bit ew,
                        input int rep);
        vec_t v;
        v = '{r, e, s, d, c, l, lv, ec, et, ew};
        for (int i = 0; i < rep; i++) vq.push_back(v);
    endtask

    initial begin
        int n, c0;
        bit seen;
        int exp_c[3];
        int exp_w[3];

        rst_n = 0; en = 1; speed_sel = 0; dir = 0; clr = 0; load = 0; load_val = 0;
        m_pre = 0; m_sel = 0; m_cnt = 0; prev_tick = 0;

        addv(0,1,0,0,0,0,0, 0,0,0, 1);
        addv(1,1,0,0,0,0,0, 0,0,0, 3);
        addv(1,1,0,0,0,0,0, 1,1,0, 1);
        addv(1,1,0,0,0,0,0, 1,0,0, 3);
        addv(1,1,0,0,0,0,0, 2,1,0, 1);
        addv(1,1,0,0,0,0,0, 2,0,0, 2);
        addv(0,1,0,0,0,0,0, 0,0,0, 1);
        addv(1,1,0,0,0,0,0, 0,0,0, 3);
        addv(1,1,0,0,0,0,0, 1,1,0, 1);
        addv(1,1,0,0,0,0,0, 1,0,0, 3);
        addv(1,1,0,0,0,1,7, 5,0,0, 1);
        addv(1,1,0,0,0,0,0, 5,0,0, 3);
        addv(1,1,0,0,0,0,0, SAT ? 5 : 0, 1, 1, 1);
        addv(1,1,0,1,0,0,0, SAT ? 5 : 0, 0, 0, 3);
        addv(1,1,0,1,0,0,0, SAT ? 4 : 5, 1, SAT ? 0 : 1, 1);
        addv(1,1,0,1,0,0,0, SAT ? 4 : 5, 0, 0, 3);
        addv(1,1,0,1,0,0,0, SAT ? 3 : 4, 1, 0, 1);
        addv(1,0,0,1,1,0,0, 0,0,0, 1);
        addv(1,0,0,1,0,0,0, 0,0,0, 2);

        foreach (vq[i]) begin
            rst_n = vq[i].r; en = vq[i].e; speed_sel = 2'(vq[i].sel); dir = vq[i].d;
            clr = vq[i].c; load = vq[i].l; load_val = 3'(vq[i].lv);
            cyc();
            check("vec_cnt", int'(cnt), vq[i].ec);
            check("vec_tick", int'(tick), int'(vq[i].et));
            check("vec_wrap", int'(wrap), int'(vq[i].ew));
        end

        // Speed change two cycles into a period
        en = 1; dir = 0; clr = 0; load = 0;
        cyc(); cyc();
        speed_sel = 2'd3;
        cyc();
        check("spd_chg_no_tick", int'(tick), 0);
        wait_tick("spd_chg_first", n);
        check("spd_chg_first", n, 5);
        wait_tick("spd_chg_period", n);
        check("spd_chg_period", n, 5);

        // Pause mid-period, then resume with the remaining cycles
        cyc(); cyc();
        c0 = int'(cnt);
        en = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tick) seen = 1;
        end
        check("pause_tick", int'(seen), 0);
        check("pause_cnt", int'(cnt), c0);
        en = 1;
        wait_tick("resume_rem", n);
        check("resume_rem", n, 3);

        // Counting up through the top of the range from 4
        speed_sel = 2'd0; load = 1; load_val = 3'd4; dir = 0;
        cyc();
        load = 0;
        check("load4", int'(cnt), 4);
        exp_c = SAT ? '{5, 5, 5} : '{5, 0, 1};
        exp_w = SAT ? '{0, 1, 1} : '{0, 1, 0};
        for (int k = 0; k < 3; k++) begin
            wait_tick("top_step", n);
            check("top_step_cnt", int'(cnt), exp_c[k]);
            check("top_step_wrap", int'(wrap), exp_w[k]);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0) speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            clr = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 24) == 0);
            load_val = 3'($urandom_range(0, 7));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/speed_ctrl_gen.md
Name: speed_ctrl_gen

Overview:
Parametrised successor to the fixed-rate speed controller used in the clock display.
- A prescaler divides clk by one of four selectable periods and emits a one-cycle tick.
- Each tick steps a modulo-N counter, up or down, with pause, clear, load and wrap/carry output.
- Drives digit/animation rates; wrap chains into the next counter stage.

Parameters:
PRE_W, 26, prescaler counter width.
P0, 36_650_000, period (clk cycles) for speed_sel=0 (250 ms).
P1, 18_325_000, period for speed_sel=1.
P2, 9_162_500, period for speed_sel=2.
P3, 4_581_250, period for speed_sel=3.
CNT_W, 6, output counter width.
CNT_MOD, 60, counter modulus; cnt spans 0..CNT_MOD-1; legal range is 2 <= CNT_MOD <= 2^CNT_W.
Each Pn must satisfy 2 <= Pn < 2^PRE_W.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, synchronous, active-low.
en  in  1  1 = run; 0 = pause prescaler and counter, holding state.
speed_sel  in  2  period select.
dir  in  1  0 = count up, 1 = count down.
clr  in  1  synchronous clear of prescaler and cnt.
load  in  1  load cnt from load_val.
load_val  in  CNT_W  value to load.
cnt  out  CNT_W  registered count.
tick  out  1  registered one-cycle pulse when cnt stepped.
wrap  out  1  registered one-cycle pulse on wrap (up: CNT_MOD-1 -> 0; down: 0 -> CNT_MOD-1).

Behaviour:
- Reset (rst_n=0 at a clk edge): pre=0, sel_q=0, cnt=0, tick=0, wrap=0. Reset is sampled only on clk edges. Reset mid-period discards partial prescale.
- Per-edge priority: rst_n, then clr, then speed change, then load, then step.
- clr=1: pre<=0, cnt<=0, tick<=0, wrap<=0. This applies regardless of en.
- Speed change (speed_sel != sel_q):
  - sel_q<=speed_sel, pre<=0, no tick that edge.
  - load is still honoured on the same edge.
  - The new period counts from the next cycle.
- load=1 (regardless of en):
  - cnt<=min(load_val, CNT_MOD-1).
  - The prescaler keeps running. If the prescaler reaches terminal on that edge, pre<=0 but the step is lost; tick=0, wrap=0.
- Step: en=1 and pre==P(sel_q)-1 gives pre<=0, tick<=1, cnt<=next(cnt, dir).
  - wrap<=1 iff the step wrapped.
  - Otherwise, if en=1, pre<=pre+1.
- en=0: pre and cnt hold; tick=0, wrap=0.
- tick and wrap are never high for two consecutive cycles (Pn >= 2).
- dir is sampled on the stepping edge only; a direction change never resets pre.
- Tick period at steady state is exactly P(sel) cycles.
- Arithmetic:
  - up: cnt==CNT_MOD-1 ? 0 : cnt+1.
  - down: cnt==0 ? CNT_MOD-1 : cnt-1.
  - Evaluated in CNT_W bits with no overflow past CNT_MOD.

Optional Feature:
SPEED_CTRL_SAT_EN.
- Defined: counter saturates instead of wrapping.
  - Up at CNT_MOD-1 holds.
  - Down at 0 holds.
  - tick still pulses; wrap pulses once on the step that attempts to pass the limit, then on each further attempted step while held.
- Undefined: modulo wrap as above.

Decomposition:
- Package speed_ctrl_pkg holds:
  - default period constants P_250MS..P_31MS.
  - speed_sel encoding constants SPD_X1/X2/X4/X8.
  - the dir encoding.
- Sub-module speed_prescaler: PRE_W counter with a period input, en, and a restart input. It outputs the terminal pulse.
- The parent holds sel_q, the period mux, and the count/load/wrap logic.

Test Plan:
Bench parameters: P0=4, P1=3, P2=2, P3=5, CNT_MOD=6, CNT_W=3.
1. Reset, en=1, sel=0, dir=0 for 30 cycles -> tick every 4 cycles; cnt 0,1..5,0; wrap coincident with the 5->0 step only. Drive rst_n=0 mid-period -> all outputs 0 next edge; first tick 4 cycles after release.
2. dir=1 from cnt=0 -> on the next tick cnt=5 with wrap=1; then 4,3 on following ticks with wrap=0.
3. Change sel 0->3 two cycles into a period -> no tick that edge; next tick exactly 5 cycles later; then 5-cycle spacing.
4. load=1, load_val=7 coincident with the terminal cycle -> cnt=5, tick=0; the next tick occurs one full period later. clr during en=0 -> cnt=0, pre=0.
5. en=0 for 10 cycles mid-period -> cnt and tick frozen; after en=1 the tick arrives after the remaining cycles of the period.
6. With SPEED_CTRL_SAT_EN, up from 4 -> cnt 5, then holds at 5; wrap=1 on each held step; tick keeps pulsing.
